// File: rtl/reset_release_seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// reset_release_seq_pkg: state encoding, counter width and a saturating increment.
// Revision 1.0
package reset_release_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    GAP     = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    FLT     = 3'd4
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_release_seq_sync_2ff.sv
`default_nettype none
`timescale 1ns/1ps
// sync_2ff: two-flop synchronizer, async active-high reset to zero.
// Revision 1.0
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/reset_release_seq.sv
`default_nettype none
`timescale 1ns/1ps
// reset_release_seq: releases P_DOMAINS resets in order, waiting for each READY.
// Revision 1.0
module reset_release_seq
  import reset_release_seq_pkg::*;
#(
  parameter int P_DOMAINS = 4,
  parameter int P_DELAY   = 16,
  parameter int P_TIMEOUT = 255
) (
  input  logic                         CLOCK,
  input  logic                         RESET,
  input  logic                         RESET_REQ,
  input  logic [P_DOMAINS-1:0]         READY,
  output logic [P_DOMAINS-1:0]         RESET_OUT_N,
  output logic                         DONE,
  output logic                         FAULT,
  output logic [$clog2(P_DOMAINS)-1:0] FAULT_IDX
);

  localparam int                 IW         = $clog2(P_DOMAINS);
  localparam logic [CNT_W-1:0]   DELAY_M1   = CNT_W'(P_DELAY - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_M1 = CNT_W'(P_TIMEOUT - 1);
  localparam logic [IW-1:0]      LAST_IDX   = IW'(P_DOMAINS - 1);
  localparam logic [P_DOMAINS-1:0] ONE      = {{(P_DOMAINS-1){1'b0}}, 1'b1};

  logic                 req_s;
  logic [P_DOMAINS-1:0] rdy_s;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [P_DOMAINS-1:0] rst_n_q, rst_n_d;
  logic                 done_q, done_d;
  logic                 fault_q, fault_d;
  logic [IW-1:0]        fidx_q, fidx_d;

  logic [P_DOMAINS-1:0] rel_mask;
  logic                 loss_any;
  logic [IW-1:0]        loss_idx;

  sync_2ff #(.WIDTH(1)) u_sync_req (
    .clk_i (CLOCK),
    .rst_i (RESET),
    .d_i   (RESET_REQ),
    .q_o   (req_s)
  );

  sync_2ff #(.WIDTH(P_DOMAINS)) u_sync_rdy (
    .clk_i (CLOCK),
    .rst_i (RESET),
    .d_i   (READY),
    .q_o   (rdy_s)
  );

  // Domains below idx are already up; in RUN every domain is watched.
  always_comb begin
    rel_mask = '0;
    loss_any = 1'b0;
    loss_idx = '0;
    for (int k = P_DOMAINS - 1; k >= 0; k--) begin
      rel_mask[k] = (state_q == RUN) ||
                    (((state_q == GAP) || (state_q == RELEASE)) && (idx_q > k[IW-1:0]));
      if (rel_mask[k] && !rdy_s[k]) begin
        loss_any = 1'b1;
        loss_idx = k[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    fault_d = fault_q;
    fidx_d  = fidx_q;
    case (state_q)
      HOLD: begin
        rst_n_d = '0;
        done_d  = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
        if (!req_s) state_d = GAP;
      end
      GAP, RELEASE, RUN: begin
        // Soft request beats READY loss, which in turn beats timeout.
        if (req_s) begin
          state_d = HOLD;
          rst_n_d = '0;
          done_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (loss_any) begin
          state_d = FLT;
          rst_n_d = '0;
          done_d  = 1'b0;
          fault_d = 1'b1;
          fidx_d  = loss_idx;
        end else if (state_q == GAP) begin
          if (cnt_q == DELAY_M1) begin
            state_d = RELEASE;
            cnt_d   = '0;
            rst_n_d = rst_n_q | (ONE << idx_q);
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end else if (state_q == RELEASE) begin
          if (rdy_s[idx_q]) begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
              idx_d   = idx_q + IW'(1);
            end
          end else if (cnt_q == TIMEOUT_M1) begin
            state_d = FLT;
            rst_n_d = '0;
            fault_d = 1'b1;
            fidx_d  = idx_q;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
      end
      FLT: begin
        rst_n_d = '0;
        done_d  = 1'b0;
        fault_d = 1'b1;
        if (req_s) begin
          state_d = HOLD;
          fault_d = 1'b0;
          fidx_d  = '0;
        end
      end
      default: begin
        state_d = HOLD;
        idx_d   = '0;
        cnt_d   = '0;
        rst_n_d = '0;
        done_d  = 1'b0;
        fault_d = 1'b0;
        fidx_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= HOLD;
      idx_q   <= '0;
      cnt_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      fidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      fidx_q  <= fidx_d;
    end
  end

  assign RESET_OUT_N = rst_n_q;
  assign DONE        = done_q;
  assign FAULT       = fault_q;
  assign FAULT_IDX   = fidx_q;

endmodule
`default_nettype wire

// File: doc/reset_release_seq.md
RESET_RELEASE_SEQ -- requirements
Module: reset_release_seq

Interface
REQ-001 The block SHALL have parameter P_DOMAINS, default 4, giving the number of reset domains released in order (2..16).
REQ-002 The block SHALL have parameter P_DELAY, default 16, giving the gap in cycles before each domain release (1..2^16-1).
REQ-003 The block SHALL have parameter P_TIMEOUT, default 255, giving the maximum cycles to wait for a domain READY (1..2^16-1).
REQ-004 Port CLOCK, input, 1 bit: single clock; all logic is on posedge.
REQ-005 Port RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port RESET_REQ, input, 1 bit: asynchronous level; while high, all domains are held in reset.
REQ-007 Port READY, input, P_DOMAINS bits: asynchronous per-domain ready/lock indication.
REQ-008 Port RESET_OUT_N, output, P_DOMAINS bits: registered active-low reset per domain; bit 0 is released first.
REQ-009 Port DONE, output, 1 bit: registered; all domains are released and ready.
REQ-010 Port FAULT, output, 1 bit: registered; a domain READY timed out or dropped.
REQ-011 Port FAULT_IDX, output, $clog2(P_DOMAINS) bits: registered index of the faulting domain.

Function
REQ-012 RESET_REQ and each READY bit SHALL pass through a 2-flop synchronizer; all timing below refers to the synchronized signals (req_s, rdy_s).
REQ-013 The FSM SHALL have states HOLD, GAP, RELEASE, RUN and FLT.
REQ-014 HOLD: all RESET_OUT_N low, DONE low, index i=0; when req_s is low, the FSM SHALL go to GAP with the gap counter cleared.
REQ-015 GAP: the FSM SHALL count exactly P_DELAY cycles, then enter RELEASE; RESET_OUT_N[i] SHALL go high on the first RELEASE cycle.
REQ-016 RELEASE: when rdy_s[i] is high and i<P_DOMAINS-1, the FSM SHALL increment i and go to GAP; when i=P_DOMAINS-1, it SHALL go to RUN and assert DONE on the next cycle.
REQ-017 RELEASE: the timeout counter SHALL start at 0 on entry; if it reaches P_TIMEOUT with rdy_s[i] low, the FSM SHALL go to FLT with FAULT_IDX=i.
REQ-018 In RUN, GAP or RELEASE, if rdy_s[k] goes low for any already-released k<i (or any k in RUN), the FSM SHALL go to FLT with FAULT_IDX equal to the lowest such k.
REQ-019 FLT: all RESET_OUT_N low, FAULT high, DONE low; the FSM SHALL remain in FLT until req_s rises, then go to HOLD and clear FAULT and FAULT_IDX.
REQ-020 If req_s goes high in GAP, RELEASE or RUN, the block SHALL drive all RESET_OUT_N low on the next cycle and go to HOLD; this takes priority over timeout and READY-loss.
REQ-021 If a timeout and a READY loss occur in the same cycle, the READY-loss FAULT_IDX SHALL win.
REQ-022 Released domains SHALL remain released (monotonic) until HOLD or FLT; no bit of RESET_OUT_N SHALL glitch.
REQ-023 The counters SHALL be 16 bits, saturating, and SHALL never wrap.

Reset
REQ-024 While RESET is high: state HOLD, RESET_OUT_N all 0, DONE 0, FAULT 0, FAULT_IDX 0, counters and synchronizers 0.
REQ-025 Asserting RESET mid-sequence SHALL immediately (asynchronously) force all RESET_OUT_N low.

Structure
REQ-026 Package reset_release_seq_pkg SHALL hold the state enum (HOLD, GAP, RELEASE, RUN, FLT) and the counter width constant (16).
REQ-027 One sub-module, sync_2ff (parameterized width, async active-high reset to 0), SHALL be instantiated for RESET_REQ and READY.

Verification
Scenarios use P_DOMAINS=4, P_DELAY=16, P_TIMEOUT=100.
REQ-028 Nominal: RESET released, RESET_REQ=0, each READY[i] raised 5 cycles after RESET_OUT_N[i] -> bits release in order 0..3, each preceded by a 16-cycle gap; DONE=1; FAULT=0.
REQ-029 Timeout: READY[2] held low -> after 100 RELEASE cycles, FAULT=1, FAULT_IDX=2, RESET_OUT_N=4'b0000.
REQ-030 READY loss in RUN: drop READY[1] -> FLT, FAULT_IDX=1, all resets low; then pulse RESET_REQ -> HOLD; after RESET_REQ=0 the full sequence repeats with DONE=1.
REQ-031 Soft request mid-sequence: raise RESET_REQ during RELEASE of domain 1 -> RESET_OUT_N=0 three cycles later (2 sync + 1 register); no FAULT.
REQ-032 Simultaneous events: READY[0] drop in the same cycle as domain 3 timeout -> FAULT_IDX=0.
REQ-033 Async reset: assert RESET for a sub-cycle pulse mid-RUN -> RESET_OUT_N=0 with no clock edge; sequence restarts from HOLD.
